// File: rtl/snake_ladder_game_ctrl.sv
// Turn-based controller for a two-player 41-square snake-and-ladder board.
// Applies dice rolls, resolves snakes/ladders/overshoot/win, and holds each new position for the animation.
module snake_ladder_game_ctrl #(
    parameter int HOLD_CYCLES = 20_000_000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iNew_Game,
    input  logic       iRoll_Valid,
    input  logic [2:0] iRoll_Val,
    output logic       oRoll_Ack,
    output logic [5:0] oP1_Pos,
    output logic [5:0] oP2_Pos,
    output logic       oTurn,
    output logic [2:0] oLast_Roll,
    output logic       oBusy,
    output logic       oGame_Over,
    output logic [1:0] oWinner
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_ROLL, MOVE, HOLD_LAND, JUMP, HOLD_JUMP, CHECK, GAME_OVER
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] hold_cnt, hold_cnt_n;
    logic [5:0]    p1_n, p2_n, cur_pos, new_pos, jump_dst;
    logic [6:0]    sum;
    logic [2:0]    last_n;
    logic [1:0]    winner_n;
    logic          turn_n, ack_n, over_n, upd_pos, is_special;

    assign cur_pos = oTurn ? oP2_Pos : oP1_Pos;
    assign sum     = {1'b0, cur_pos} + {4'b0, oLast_Roll};

    always_comb begin
        is_special = 1'b1;
        jump_dst   = cur_pos;
        case (cur_pos)
            6'd3:    jump_dst = 6'd10;
            6'd8:    jump_dst = 6'd17;
            6'd23:   jump_dst = 6'd30;
            6'd11:   jump_dst = 6'd0;
            6'd26:   jump_dst = 6'd14;
            6'd35:   jump_dst = 6'd32;
            default: is_special = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        last_n     = oLast_Roll;
        turn_n     = oTurn;
        ack_n      = 1'b0;
        over_n     = oGame_Over;
        winner_n   = oWinner;
        upd_pos    = 1'b0;
        new_pos    = cur_pos;
        case (state)
            WAIT_ROLL: begin
                if (iRoll_Valid && iRoll_Val >= 3'd1 && iRoll_Val <= 3'd6) begin
                    last_n  = iRoll_Val;
                    ack_n   = 1'b1;
                    state_n = MOVE;
                end
            end
            MOVE: begin
                if (sum > 7'd40) begin
                    state_n = CHECK;
                end else begin
                    upd_pos    = 1'b1;
                    new_pos    = sum[5:0];
                    hold_cnt_n = '0;
                    state_n    = HOLD_LAND;
                end
            end
            HOLD_LAND: begin
                if (hold_cnt == HOLD_LAST) state_n = is_special ? JUMP : CHECK;
                else hold_cnt_n = hold_cnt + CW'(1);
            end
            JUMP: begin
                upd_pos    = 1'b1;
                new_pos    = jump_dst;
                hold_cnt_n = '0;
                state_n    = HOLD_JUMP;
            end
            HOLD_JUMP: begin
                if (hold_cnt == HOLD_LAST) state_n = CHECK;
                else hold_cnt_n = hold_cnt + CW'(1);
            end
            CHECK: begin
                if (cur_pos == 6'd40) begin
                    over_n   = 1'b1;
                    winner_n = {oTurn, ~oTurn};  // P1 -> 1, P2 -> 2
                    state_n  = GAME_OVER;
                end else begin
                    turn_n  = ~oTurn;
                    state_n = WAIT_ROLL;
                end
            end
            GAME_OVER: state_n = GAME_OVER;
            default:   state_n = WAIT_ROLL;
        endcase
        p1_n = (upd_pos && !oTurn) ? new_pos : oP1_Pos;
        p2_n = (upd_pos &&  oTurn) ? new_pos : oP2_Pos;
    end

    always_ff @(posedge iClk) begin
        if (iRst || iNew_Game) begin
            state      <= WAIT_ROLL;
            hold_cnt   <= '0;
            oP1_Pos    <= '0;
            oP2_Pos    <= '0;
            oTurn      <= 1'b0;
            oLast_Roll <= '0;
            oRoll_Ack  <= 1'b0;
            oBusy      <= 1'b0;
            oGame_Over <= 1'b0;
            oWinner    <= '0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            oP1_Pos    <= p1_n;
            oP2_Pos    <= p2_n;
            oTurn      <= turn_n;
            oLast_Roll <= last_n;
            oRoll_Ack  <= ack_n;
            oBusy      <= (state_n != WAIT_ROLL) && (state_n != GAME_OVER);
            oGame_Over <= over_n;
            oWinner    <= winner_n;
        end
    end
endmodule

// File: tb/tb_snake_ladder_game_ctrl.sv
// Bench for snake_ladder_game_ctrl: timeline-based reference model checked every cycle,
// directed game scenarios with literal expectations, then randomized play.
module tb_snake_ladder_game_ctrl;
    localparam int H = 4;

    logic       iClk, iRst, iNew_Game, iRoll_Valid;
    logic [2:0] iRoll_Val;
    logic       oRoll_Ack, oTurn, oBusy, oGame_Over;
    logic [5:0] oP1_Pos, oP2_Pos;
    logic [2:0] oLast_Roll;
    logic [1:0] oWinner;

    snake_ladder_game_ctrl #(.HOLD_CYCLES(H)) dut (
        .iClk(iClk), .iRst(iRst), .iNew_Game(iNew_Game),
        .iRoll_Valid(iRoll_Valid), .iRoll_Val(iRoll_Val),
        .oRoll_Ack(oRoll_Ack), .oP1_Pos(oP1_Pos), .oP2_Pos(oP2_Pos),
        .oTurn(oTurn), .oLast_Roll(oLast_Roll), .oBusy(oBusy),
        .oGame_Over(oGame_Over), .oWinner(oWinner)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int jump_of(input int s);
        case (s)
            3: return 10;   8: return 17;  23: return 30;
            11: return 0;  26: return 14;  35: return 32;
            default: return s;
        endcase
    endfunction

    // Reference model: on each accepted roll, schedule the edges at which things change.
    int mp[2];
    int cyc = 0, who = 0, land = 0, dest = 0, t_land = 0, t_jump = 0, t_end = 0;
    int mlast = 0, mwin = 0;
    bit mturn = 0, mack = 0, mbusy = 0, mover = 0, pending = 0, started = 0;

    always @(posedge iClk) begin
        cyc++;
        mack = 0;
        if (iRst || iNew_Game) begin
            if (iRst) started = 1;
            mp[0] = 0; mp[1] = 0; mturn = 0; mlast = 0; mbusy = 0;
            mover = 0; mwin = 0; pending = 0;
        end else if (pending) begin
            if (cyc == t_land) mp[who] = land;
            if (cyc == t_jump) mp[who] = dest;
            if (cyc == t_end) begin
                if (mp[who] == 40) begin
                    mover = 1;
                    mwin  = who + 1;
                end else begin
                    mturn = ~mturn;
                end
                mbusy   = 0;
                pending = 0;
            end
        end else if (!mover && iRoll_Valid && iRoll_Val >= 1 && iRoll_Val <= 6) begin
            mack = 1; mbusy = 1; pending = 1;
            mlast = int'(iRoll_Val);
            who   = int'(mturn);
            land  = mp[who] + mlast;
            t_land = 0; t_jump = 0;
            if (land > 40) begin
                t_end = cyc + 2;
            end else begin
                t_land = cyc + 1;
                dest   = jump_of(land);
                if (dest != land) begin
                    t_jump = cyc + 2 + H;
                    t_end  = cyc + 3 + 2 * H;
                end else begin
                    t_end = cyc + 2 + H;
                end
            end
        end
    end

    always @(negedge iClk) begin
        if (started) begin
            chk("p1_pos",    oP1_Pos,    mp[0]);
            chk("p2_pos",    oP2_Pos,    mp[1]);
            chk("turn",      oTurn,      mturn);
            chk("last_roll", oLast_Roll, mlast);
            chk("roll_ack",  oRoll_Ack,  mack);
            chk("busy",      oBusy,      mbusy);
            chk("game_over", oGame_Over, mover);
            chk("winner",    oWinner,    mwin);
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (oBusy === 1'b1 && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still high after %0d cycles", n);
        end
    endtask

    task automatic do_roll(input int v);
        iRoll_Valid = 1'b1;
        iRoll_Val   = 3'(v);
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        iRst = 1'b1; iNew_Game = 1'b0; iRoll_Valid = 1'b0; iRoll_Val = '0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;

        // Reset asserted mid-hold
        iRoll_Valid = 1'b1; iRoll_Val = 3'd5;
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        repeat (3) @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        chk("rst_p1", oP1_Pos, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_last", oLast_Roll, 0);
        chk("rst_turn", oTurn, 0);
        @(negedge iClk);
        chk("rst_idle_busy", oBusy, 0);

        // P1 roll 3 -> ladder to 10
        iRoll_Valid = 1'b1; iRoll_Val = 3'd3;
        @(negedge iClk);                       // after E0
        iRoll_Valid = 1'b0;
        chk("s2_ack_e0", oRoll_Ack, 1);
        @(negedge iClk);                       // after E1
        chk("s2_ack_e1", oRoll_Ack, 0);
        chk("s2_p1_e1", oP1_Pos, 3);
        repeat (4) @(negedge iClk);            // after E5
        chk("s2_p1_e5", oP1_Pos, 3);
        @(negedge iClk);                       // after E6
        chk("s2_p1_e6", oP1_Pos, 10);
        repeat (4) @(negedge iClk);            // after E10
        chk("s2_turn_e10", oTurn, 0);
        @(negedge iClk);                       // after E11
        chk("s2_turn_e11", oTurn, 1);
        chk("s2_p2", oP2_Pos, 0);

        // Bring P2 to 9: P2 6, P1 1 (snake 11->0), P2 3, P1 2
        do_roll(6); do_roll(1); do_roll(3); do_roll(2);
        chk("s3_p2_pre", oP2_Pos, 9);
        chk("s3_p1_pre", oP1_Pos, 2);
        iRoll_Valid = 1'b1; iRoll_Val = 3'd2;
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        @(negedge iClk);
        chk("s3_p2_land", oP2_Pos, 11);
        iRoll_Valid = 1'b1; iRoll_Val = 3'd5;  // dropped while busy
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        chk("s3_busy_ack", oRoll_Ack, 0);
        chk("s3_busy_last", oLast_Roll, 2);
        wait_idle();
        chk("s3_p2_snake", oP2_Pos, 0);
        chk("s3_turn", oTurn, 0);

        // Walk P1 to 38
        do_roll(6); do_roll(1); do_roll(6); do_roll(1); do_roll(6);
        do_roll(1); do_roll(2); do_roll(1);
        chk("s4_p1_pre", oP1_Pos, 38);
        iRoll_Valid = 1'b1; iRoll_Val = 3'd5;
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        @(negedge iClk);
        chk("s4_over_turn_e1", oTurn, 0);
        @(negedge iClk);
        chk("s4_over_turn_e2", oTurn, 1);
        chk("s4_over_p1", oP1_Pos, 38);
        do_roll(1);
        iRoll_Valid = 1'b1; iRoll_Val = 3'd2;
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        @(negedge iClk);
        chk("s4_p1_40", oP1_Pos, 40);
        repeat (4) @(negedge iClk);
        chk("s4_over_e5", oGame_Over, 0);
        @(negedge iClk);
        chk("s4_over_e6", oGame_Over, 1);
        chk("s4_winner", oWinner, 1);
        iRoll_Valid = 1'b1; iRoll_Val = 3'd4;
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        chk("s4_post_ack", oRoll_Ack, 0);

        // Illegal values, then restart colliding with a roll
        iRoll_Valid = 1'b1; iRoll_Val = 3'd0;
        @(negedge iClk);
        iRoll_Val = 3'd7;
        @(negedge iClk);
        chk("s5_ack7", oRoll_Ack, 0);
        iNew_Game = 1'b1; iRoll_Val = 3'd4;
        @(negedge iClk);
        iNew_Game = 1'b0; iRoll_Valid = 1'b0;
        chk("s5_p1", oP1_Pos, 0);
        chk("s5_over", oGame_Over, 0);
        chk("s5_ack", oRoll_Ack, 0);
        @(negedge iClk);
        chk("s5_ack_next", oRoll_Ack, 0);
        chk("s5_busy", oBusy, 0);

        // Walk both to 32, then P1 rolls 3 onto the snake at 35
        for (int i = 0; i < 10; i++) do_roll(6);
        do_roll(2); do_roll(2);
        iRoll_Valid = 1'b1; iRoll_Val = 3'd0;
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        chk("s6_tie_p1", oP1_Pos, 32);
        chk("s6_tie_p2", oP2_Pos, 32);
        iRoll_Valid = 1'b1; iRoll_Val = 3'd3;
        @(negedge iClk);
        iRoll_Valid = 1'b0;
        @(negedge iClk);
        chk("s6_p1_35", oP1_Pos, 35);
        wait_idle();
        chk("s6_p1_32", oP1_Pos, 32);

        // Randomized play
        for (int i = 0; i < 6000; i++) begin
            iRoll_Valid = ($urandom_range(2) == 0);
            iRoll_Val   = 3'($urandom_range(7));
            iNew_Game   = ($urandom_range(499) == 0);
            iRst        = ($urandom_range(999) == 0);
            @(negedge iClk);
        end
        iRoll_Valid = 1'b0; iNew_Game = 1'b0; iRst = 1'b0;
        repeat (5) @(negedge iClk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
